// File: rtl/apb_mem_pkg.sv
// Shared types and constants for the APB4 memory slave with programmable wait states.
package apb_mem_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } apb_state_t;

  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  function automatic int strb_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/apb_mem_slave_wait_if.sv
// APB4 completer-side bus bundle; the master modport drives requests, the slave modport answers.
interface apb_mem_slave_wait_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic [DATA_W-1:0]     PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR
  );

endinterface

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_W word store with byte-lane write strobes and an unregistered read port.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            we,
  input  logic [ADDR_W-1:0]               addr,
  input  logic [DATA_W-1:0]               wdata,
  input  logic [strb_width(DATA_W)-1:0]   strb,
  output logic [DATA_W-1:0]               rdata
);

  localparam int STRB_W = strb_width(DATA_W);
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = addr[IDX_W-1:0];
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(DEPTH));
  assign rdata    = in_range ? mem[idx] : '0;

  // NOTE: clearing every word on reset forces this store into flops rather than
  // a RAM macro; acceptable here because the cleared-after-reset contents are
  // visible to software.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we && in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (strb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: rtl/apb_mem_slave_wait.sv
// APB4 memory slave: setup/access FSM, wait-state counter, out-of-range error flag and registered read data.
module apb_mem_slave_wait
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_mem_slave_wait_if.slave  apb
);

  localparam int WS = (WAIT_STATES > WAIT_MAX) ? WAIT_MAX : WAIT_STATES;

  apb_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] rd_word;
  logic              addr_err;
  logic              ready;
  logic              wr_en;

  assign addr_err = ({1'b0, apb.PADDR} >= (ADDR_W+1)'(DEPTH));

  // PREADY decodes registered state only, so no input reaches it combinationally.
  assign ready = (state == ACCESS) && (cnt == CNT_W'(WS));
  assign wr_en = ready && apb.PSEL && apb.PENABLE && apb.PWRITE && !err;

  assign apb.PRDATA  = rdata;
  assign apb.PREADY  = ready;
  assign apb.PSLVERR = ready && err;

  apb_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .addr  (apb.PADDR),
    .wdata (apb.PWDATA),
    .strb  (apb.PSTRB),
    .rdata (rd_word)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          // PSEL with PENABLE already high has no setup phase and is ignored.
          if (apb.PSEL && !apb.PENABLE) begin
            state <= ACCESS;
            cnt   <= '0;
            err   <= addr_err;
            if (!apb.PWRITE) rdata <= addr_err ? '0 : rd_word;
          end
        end
        ACCESS: begin
          if (!apb.PSEL) begin
            state <= IDLE;
          end else if (apb.PENABLE) begin
            if (ready) state <= IDLE;
            else       cnt   <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_slave_wait.sv
// Directed scoreboard bench: two slave configurations, expected responses queued at issue and checked by monitors.
module tb_apb_mem_slave_wait;

  localparam int WS_A = 2;
  localparam int WS_B = 0;

  typedef struct packed {
    logic        rd;
    logic [15:0] data;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 clk = ~clk;

  apb_mem_slave_wait_if #(.ADDR_W(4), .DATA_W(16)) ia ();
  apb_mem_slave_wait_if #(.ADDR_W(4), .DATA_W(8))  ib ();

  apb_mem_slave_wait #(.ADDR_W(4), .DATA_W(16), .DEPTH(12), .WAIT_STATES(WS_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .apb (ia.slave)
  );

  apb_mem_slave_wait #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WAIT_STATES(WS_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .apb (ib.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every completing access cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (ia.PSEL && ia.PENABLE && ia.PREADY) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_a_unexpected: completion with empty queue at %0t", $time);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        check("pslverr_a", 32'(ia.PSLVERR), 32'(e.err));
        if (e.rd) check("prdata_a", 32'(ia.PRDATA), 32'(e.data));
      end
    end
  end

  always @(negedge clk) begin
    if (ib.PSEL && ib.PENABLE && ib.PREADY) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_b_unexpected: completion with empty queue at %0t", $time);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        check("pslverr_b", 32'(ib.PSLVERR), 32'(e.err));
        if (e.rd) check("prdata_b", 32'(ib.PRDATA), {24'h0, e.data[7:0]});
      end
    end
  end

  // One transfer; returns on the negedge of the completing cycle with the bus still
  // in access phase, so a following call starts its setup right after completion.
  task automatic xfer_a(input logic wr, input logic [3:0] addr, input logic [15:0] wd,
                        input logic [1:0] st, input logic [15:0] exp_rd, input logic exp_err);
    int n;
    @(posedge clk); #1;
    ia.PSEL = 1'b1; ia.PENABLE = 1'b0; ia.PWRITE = wr;
    ia.PADDR = addr; ia.PWDATA = wd; ia.PSTRB = st;
    q_a.push_back('{rd: !wr, data: exp_rd, err: exp_err});
    @(posedge clk); #1 ia.PENABLE = 1'b1;
    n = 1;
    @(negedge clk);
    while (!ia.PREADY && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency_a", 32'(n), 32'(WS_A + 1));
  endtask

  task automatic xfer_b(input logic wr, input logic [3:0] addr, input logic [7:0] wd,
                        input logic [7:0] exp_rd);
    int n;
    @(posedge clk); #1;
    ib.PSEL = 1'b1; ib.PENABLE = 1'b0; ib.PWRITE = wr;
    ib.PADDR = addr; ib.PWDATA = wd; ib.PSTRB = 1'b1;
    q_b.push_back('{rd: !wr, data: {8'h0, exp_rd}, err: 1'b0});
    @(posedge clk); #1 ib.PENABLE = 1'b1;
    n = 1;
    @(negedge clk);
    while (!ib.PREADY && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("latency_b", 32'(n), 32'(WS_B + 1));
  endtask

  task automatic idle_bus();
    @(posedge clk); #1;
    ia.PSEL = 1'b0; ia.PENABLE = 1'b0;
    ib.PSEL = 1'b0; ib.PENABLE = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    ia.PSEL = 1'b0; ia.PENABLE = 1'b0; ia.PWRITE = 1'b0;
    ia.PADDR = '0;  ia.PWDATA = '0;    ia.PSTRB = '0;
    ib.PSEL = 1'b0; ib.PENABLE = 1'b0; ib.PWRITE = 1'b0;
    ib.PADDR = '0;  ib.PWDATA = '0;    ib.PSTRB = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_pready_a",  32'(ia.PREADY),  32'd0);
    check("reset_pslverr_a", 32'(ia.PSLVERR), 32'd0);
    check("reset_prdata_a",  32'(ia.PRDATA),  32'd0);
    check("reset_pready_b",  32'(ib.PREADY),  32'd0);

    // Full write then read with two wait states.
    xfer_a(1'b1, 4'd3, 16'hBEEF, 2'b11, 16'h0000, 1'b0);
    xfer_a(1'b0, 4'd3, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
    idle_bus();

    // Byte-lane merge and an all-lanes-off write.
    xfer_a(1'b1, 4'd5, 16'h1234, 2'b11, 16'h0000, 1'b0);
    xfer_a(1'b1, 4'd5, 16'hAB00, 2'b10, 16'h0000, 1'b0);
    xfer_a(1'b1, 4'd5, 16'hFFFF, 2'b00, 16'h0000, 1'b0);
    xfer_a(1'b0, 4'd5, 16'h0000, 2'b00, 16'hAB34, 1'b0);
    idle_bus();

    // Out-of-range accesses, first illegal word, last legal word.
    xfer_a(1'b1, 4'd13, 16'h5555, 2'b11, 16'h0000, 1'b1);
    xfer_a(1'b0, 4'd13, 16'h0000, 2'b00, 16'h0000, 1'b1);
    xfer_a(1'b0, 4'd12, 16'h0000, 2'b00, 16'h0000, 1'b1);
    xfer_a(1'b0, 4'd11, 16'h0000, 2'b00, 16'h0000, 1'b0);
    idle_bus();

    // Access phase without a setup phase must be ignored.
    @(posedge clk); #1;
    ia.PSEL = 1'b1; ia.PENABLE = 1'b1; ia.PWRITE = 1'b1;
    ia.PADDR = 4'd3; ia.PWDATA = 16'h0000; ia.PSTRB = 2'b11;
    @(negedge clk);
    check("noset_pready_a", 32'(ia.PREADY), 32'd0);
    @(negedge clk);
    check("noset_pready_a2", 32'(ia.PREADY), 32'd0);
    idle_bus();

    // Master abort during the first wait cycle of a write.
    @(posedge clk); #1;
    ia.PSEL = 1'b1; ia.PENABLE = 1'b0; ia.PWRITE = 1'b1;
    ia.PADDR = 4'd4; ia.PWDATA = 16'h4444; ia.PSTRB = 2'b11;
    @(posedge clk); #1;
    ia.PSEL = 1'b0; ia.PENABLE = 1'b1;
    @(negedge clk);
    check("abort_pready_a", 32'(ia.PREADY), 32'd0);
    idle_bus();
    @(negedge clk);
    check("abort_idle_a", 32'(ia.PREADY), 32'd0);
    xfer_a(1'b0, 4'd4, 16'h0000, 2'b00, 16'h0000, 1'b0);

    // Back-to-back reads with no idle cycle between them.
    xfer_a(1'b0, 4'd3, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
    xfer_a(1'b0, 4'd5, 16'h0000, 2'b00, 16'hAB34, 1'b0);
    idle_bus();

    // Zero-wait 8-bit configuration: fill every word then read it back.
    for (int j = 0; j < 16; j++) xfer_b(1'b1, 4'(j), 8'(j + 6), 8'h00);
    for (int j = 0; j < 16; j++) xfer_b(1'b0, 4'(j), 8'h00, 8'(j + 6));
    idle_bus();

    // Reset on the second wait cycle of a write to addr 0.
    @(posedge clk); #1;
    ia.PSEL = 1'b1; ia.PENABLE = 1'b0; ia.PWRITE = 1'b1;
    ia.PADDR = 4'd0; ia.PWDATA = 16'h7777; ia.PSTRB = 2'b11;
    @(posedge clk); #1 ia.PENABLE = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; ia.PSEL = 1'b0; ia.PENABLE = 1'b0;
    @(negedge clk);
    check("rst_mid_pready_a",  32'(ia.PREADY),  32'd0);
    check("rst_mid_pslverr_a", 32'(ia.PSLVERR), 32'd0);
    check("rst_mid_prdata_a",  32'(ia.PRDATA),  32'd0);
    xfer_a(1'b0, 4'd0, 16'h0000, 2'b00, 16'h0000, 1'b0);
    xfer_a(1'b0, 4'd3, 16'h0000, 2'b00, 16'h0000, 1'b0);
    idle_bus();

    repeat (4) @(posedge clk);
    check("queue_a_drained", 32'(q_a.size()), 32'd0);
    check("queue_b_drained", 32'(q_b.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_mem_slave_wait.md
Name: apb_mem_slave_wait

Overview:
- Parametrised APB4 memory slave: DEPTH words of DATA_W bits, byte-lane write strobes, programmable wait states, PSLVERR on out-of-range access.
- Next generation of the team's fixed 16x8 APB memory slave. Sits behind an APB bridge as a generic register/scratch RAM target.
- Completes one transfer at a time. Each transfer is a setup phase followed by an access phase, and may be extended by wait states.

Parameters:
- ADDR_W, 4: PADDR width in bits.
- DATA_W, 8: data width in bits; legal values are 8, 16, 32 (multiple of 8).
- DEPTH, 16: number of implemented words; DEPTH <= 2**ADDR_W.
- WAIT_STATES, 0: PREADY-low cycles inserted in every access phase; range 0..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  word address.
- PWDATA  in  DATA_W  write data.
- PSTRB  in  DATA_W/8  write byte-lane enables; ignored on reads.
- PRDATA  out  DATA_W  read data; registered.
- PREADY  out  1  transfer completes this cycle.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - state = IDLE, wait counter = 0, PRDATA = 0.
  - All memory words are cleared to 0.
  - PREADY = 0 and PSLVERR = 0 in the cycle after reset.
  - Reset wins over any in-flight transfer. No write is committed at that edge.
- FSM states: IDLE and ACCESS.
  - IDLE -> ACCESS on an edge where PSEL=1 and PENABLE=0 (setup phase). At that edge:
    - counter <= 0.
    - err <= (PADDR >= DEPTH).
    - PRDATA <= (read and not err) ? mem[PADDR] : 0. On writes PRDATA holds its previous value.
  - IDLE with PSEL=1 and PENABLE=1 (no preceding setup) is a protocol violation: stay in IDLE, no side effects.
  - In ACCESS:
    - PREADY = (counter == WAIT_STATES). This is a decode of registered state with no combinational path from the inputs.
    - PSLVERR = PREADY and err.
  - ACCESS, PSEL=1, PENABLE=1, PREADY=0: counter <= counter + 1.
  - ACCESS, PSEL=1, PENABLE=1, PREADY=1 (completion edge):
    - If a write and not err, mem[PADDR] is updated per byte lane: byte i <= PWDATA byte i when PSTRB[i]=1.
    - state -> IDLE.
  - ACCESS, PSEL=0 (master abort): state -> IDLE, no write, PRDATA unchanged.
- Latency:
  - Access phase lasts WAIT_STATES+1 cycles.
  - With WAIT_STATES=0 the transfer takes 2 cycles (setup + access), matching the legacy slave.
- Back-to-back transfers: the cycle after a completion edge may be a new setup phase. IDLE accepts it immediately, with no dead cycle.
- Error transfers (PADDR >= DEPTH):
  - Write: memory unchanged.
  - Read: PRDATA = 0.
  - PREADY timing is identical to a good access, i.e. wait states still apply.
- Write with PSTRB = 0: completes normally with PSLVERR=0 and memory unchanged.
- PADDR, PWRITE and PWDATA must be stable from setup through completion. The write address is sampled at the completion edge.
- Outside ACCESS: PREADY = 0 and PSLVERR = 0.

Decomposition:
- Package apb_mem_pkg holds:
  - typedef enum logic {IDLE, ACCESS} apb_state_t.
  - Localparam helper for strobe width (DATA_W/8).
  - WAIT_STATES maximum constant (15) and the counter width (4).
- Sub-module apb_mem_array holds DEPTH x DATA_W storage with:
  - Synchronous clear on rst.
  - Byte-strobe write port.
  - Combinational read by address, registered into PRDATA by the parent.
- Parent module keeps the FSM, wait counter, error flag, and the PREADY/PSLVERR decode.

Test Plan (ADDR_W=4, DATA_W=16, DEPTH=12, WAIT_STATES=2 unless noted):
- Write 0xBEEF to addr 3 with PSTRB=2'b11, then read addr 3 -> PREADY low for 2 access cycles and high on the 3rd; PRDATA=0xBEEF, PSLVERR=0.
- Write 0x1234 to addr 5 with PSTRB=11, then 0xAB00 with PSTRB=2'b10, then read addr 5 -> PRDATA=0xAB34.
- Write 0x5555 to addr 13 (out of range) -> PSLVERR=1 with PREADY on the 3rd access cycle. Read addr 13 -> PRDATA=0, PSLVERR=1. Read addr 11 -> still 0 from reset.
- Assert rst on the 2nd wait cycle of a write 0x7777 to addr 0 -> PREADY=0 and PSLVERR=0 next cycle; read addr 0 after reset -> 0x0000.
- Abort: drop PSEL during the 1st wait cycle of a write to addr 4 -> FSM returns to IDLE and addr 4 reads 0. Then issue back-to-back reads of addr 3 and addr 5 with no idle cycle -> both complete, returning 0xBEEF and 0xAB34.
- WAIT_STATES=0, DATA_W=8, DEPTH=16: write j+6 to addr j for j=0..15, then read all 16 -> each transfer takes 2 cycles, PREADY=1 on every access cycle, and PRDATA=j+6 for each j.
